// File: rtl/servant_mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package servant_mdu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIN  = 2'd2,
      ST_HOLD = 2'd3
   } mdu_state_e;

   // rs1 is signed for MULH, MULHSU, DIV, REM
   function automatic logic rs1_signed(input logic [2:0] f);
      return f[2] ? !f[0] : (f[1:0] == 2'b01 || f[1:0] == 2'b10);
   endfunction

   // rs2 is signed for MULH, DIV, REM
   function automatic logic rs2_signed(input logic [2:0] f);
      return f[2] ? !f[0] : (f[1:0] == 2'b01);
   endfunction

endpackage

// File: rtl/servant_mdu_core.sv
// Bit-serial datapath: one shared 33b add/sub, hi/lo shift registers and the iteration counter.
module servant_mdu_core
   import servant_mdu_pkg::*;
#(
   parameter bit RST_DATA = 1'b0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_step,
   input  logic            i_div,
   input  logic [XLEN-1:0] i_opa,
   input  logic [XLEN-1:0] i_opl,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo,
   output logic            o_last_c
);

   logic [XLEN-1:0]  hi;
   logic [XLEN-1:0]  lo;
   logic [XLEN-1:0]  opa;
   logic [CNT_W-1:0] cnt;
   logic [XLEN:0]    x;
   logic [XLEN+1:0]  sum;
   logic [XLEN:0]    mul_s;

   // mul: hi + multiplicand; div: {rem,next dividend bit} - divisor, sum[33] = no borrow
   always_comb begin
      x     = i_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
      sum   = {1'b0, x} + (i_div ? {2'b01, ~opa} : {2'b00, opa}) + (XLEN+2)'(i_div);
      mul_s = lo[0] ? sum[XLEN:0] : x;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         cnt <= '0;
      else if (i_start)
         cnt <= '0;
      else if (i_step)
         cnt <= cnt + CNT_W'(1);
   end

   // lo holds the multiplier (shifted out LSB first) or dividend/quotient (shifted MSB first)
   always_ff @(posedge i_clk) begin
      if (RST_DATA && i_rst) begin
         hi  <= '0;
         lo  <= '0;
         opa <= '0;
      end else if (i_start) begin
         hi  <= '0;
         lo  <= i_opl;
         opa <= i_opa;
      end else if (i_step) begin
         if (i_div) begin
            hi <= sum[XLEN+1] ? sum[XLEN-1:0] : x[XLEN-1:0];
            lo <= {lo[XLEN-2:0], sum[XLEN+1]};
         end else begin
            hi <= mul_s[XLEN:1];
            lo <= {mul_s[0], lo[XLEN-1:1]};
         end
      end
   end

   assign o_hi     = hi;
   assign o_lo     = lo;
   assign o_last_c = (cnt == CNT_W'(ITER - 1));

endmodule

// File: rtl/servant_mdu.sv
// RV32M multiply/divide unit for servant: FSM, operand abs/negate and result select.
module servant_mdu
   import servant_mdu_pkg::*;
#(
   parameter string RESET_STRATEGY = "MINI"
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_rd,
   output logic            o_ready
);

   // Control state always resets so an aborted op can never complete
   localparam bit RST_RD  = (RESET_STRATEGY != "NONE");
   localparam bit RST_ALL = (RESET_STRATEGY != "NONE") && (RESET_STRATEGY != "MINI");

   mdu_state_e      state;
   mdu_op_e         op;
   logic            neg_res;
   logic            sa;
   logic            sb;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic            neg_c;
   logic            start_c;
   logic            step_c;
   logic            last_c;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [2*XLEN-1:0] prod_n;
   logic [XLEN-1:0] res_c;

   always_comb begin
      sa    = i_rs1[XLEN-1] & rs1_signed(i_funct3);
      sb    = i_rs2[XLEN-1] & rs2_signed(i_funct3);
      abs_a = sa ? -i_rs1 : i_rs1;
      abs_b = sb ? -i_rs2 : i_rs2;
      unique case (mdu_op_e'(i_funct3))
         MDU_MULH:   neg_c = sa ^ sb;
         MDU_MULHSU: neg_c = sa;
         MDU_DIV:    neg_c = (sa ^ sb) & (i_rs2 != '0);
         MDU_REM:    neg_c = sa;
         default:    neg_c = 1'b0;
      endcase
   end

   assign start_c = (state == ST_IDLE) && i_valid;
   assign step_c  = (state == ST_BUSY);

   servant_mdu_core #(.RST_DATA(RST_ALL)) u_core (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (start_c),
      .i_step   (step_c),
      .i_div    (op[2]),
      .i_opa    (i_funct3[2] ? abs_b : abs_a),
      .i_opl    (i_funct3[2] ? abs_a : abs_b),
      .o_hi     (hi),
      .o_lo     (lo),
      .o_last_c (last_c)
   );

   // div leaves rem in hi and quotient in lo; mul leaves the 64b product in {hi,lo}
   always_comb begin
      prod_n = neg_res ? -{hi, lo} : {hi, lo};
      unique case (op)
         MDU_MUL:                         res_c = lo;
         MDU_MULH, MDU_MULHSU, MDU_MULHU: res_c = prod_n[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:               res_c = neg_res ? -lo : lo;
         default:                         res_c = neg_res ? -hi : hi;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         o_ready <= 1'b0;
         if (RST_RD)
            o_rd <= '0;
         if (RST_ALL) begin
            op      <= MDU_MUL;
            neg_res <= 1'b0;
         end
      end else begin
         o_ready <= 1'b0;
         unique case (state)
            ST_IDLE:
               if (i_valid) begin
                  op      <= mdu_op_e'(i_funct3);
                  neg_res <= neg_c;
                  state   <= ST_BUSY;
               end
            ST_BUSY:
               if (last_c)
                  state <= ST_FIN;
            ST_FIN: begin
               o_rd    <= res_c;
               o_ready <= 1'b1;
               state   <= ST_HOLD;
            end
            // wait for valid to drop so a stale request is not relaunched
            ST_HOLD:
               if (!i_valid)
                  state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end
   end

endmodule
